core_jmp_multi: RTL and testbench

- Parametrised, multi-lane branch resolution unit in the execute stage; successor to the single-lane jump resolver.
- Resolves up to NUM_LANES branches per cycle against BPU predictions and selects the oldest mispredicting lane.
- Issues one registered redirect and queues BPU corrections in a DEPTH-entry FIFO drained by the BPU over valid/ready.
- Keeps saturating branch/miss/drop counters.

---
 rtl/core_jmp_multi_pkg.sv | 50 +++++
 rtl/core_jmp_lane.sv | 87 ++++++++
 rtl/core_jmp_multi.sv | 235 +++++++++++++++++++++++
 tb/tb_core_jmp_multi.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_jmp_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_jmp_multi_pkg
//  Description : Shared pipeline types for the multi-lane branch resolver.
//                Defines the BPU prediction/correction records, the branch
//                target-type encodings and the compare-type bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
package core_jmp_multi_pkg;

    // Branch target classes
    localparam logic [1:0] _BPU_TARGET_NPC    = 2'd0;
    localparam logic [1:0] _BPU_TARGET_CALL   = 2'd1;
    localparam logic [1:0] _BPU_TARGET_RETURN = 2'd2;
    localparam logic [1:0] _BPU_TARGET_IMM    = 2'd3;

    // cmp_type bit positions: bit0 selects signed compare, bits 3..1 enable
    // the r1<r0, r1==r0 and r1>r0 outcomes respectively.
    localparam int c_CMP_SIGNED = 0;
    localparam int c_CMP_GT     = 1;
    localparam int c_CMP_EQ     = 2;
    localparam int c_CMP_LT     = 3;

    // Return-address-stack pointer and miss-type widths
    localparam int c_RAS_W      = 3;
    localparam int c_RAS_MISS_W = 2;

    localparam logic [c_RAS_W-1:0] c_RAS_ONE = 1;

    typedef struct packed {
        logic               taken;        // predicted taken
        logic [1:0]         target_type;  // predicted target class
        logic [31:0]        predict_pc;   // predicted target address
        logic               pc_off;       // slot of the predicted branch in its fetch pair
        logic [c_RAS_W-1:0] ras_ptr;      // RAS pointer at prediction time
    } bpu_predict_t;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    miss;
        logic                    true_taken;
        logic                    true_conditional_jmp;
        logic [1:0]              true_target_type;
        logic [31:0]             true_target;
        logic [c_RAS_W-1:0]      ras_ptr;
        logic [c_RAS_MISS_W-1:0] ras_miss_type;
    } bpu_correct_t;

endpackage
`default_nettype wire

// File: rtl/core_jmp_lane.sv
`default_nettype none
// ============================================================================
//  Module      : core_jmp_lane
//  Description : Combinational resolution of one branch lane: operand
//                compare, misprediction detection, redirect address and
//                BPU correction record.
//  Ports       : i_valid, i_target_type, i_cmp_type, i_predict, i_pc,
//                i_target, i_r0, i_r1  -> lane inputs
//                o_miss          lane mispredicted
//                o_need_update   lane needs a BPU correction
//                o_redirect_pc   resolved next PC for this lane
//                o_corr          correction record for this lane
//  Revision    : 1.0  initial release
// ============================================================================
module core_jmp_lane
    import core_jmp_multi_pkg::*;
(
    input  logic         i_valid,
    input  logic [1:0]   i_target_type,
    input  logic [3:0]   i_cmp_type,
    input  bpu_predict_t i_predict,
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_target,
    input  logic [31:0]  i_r0,
    input  logic [31:0]  i_r1,
    output logic         o_miss,
    output logic         o_need_update,
    output logic [31:0]  o_redirect_pc,
    output bpu_correct_t o_corr
);

    logic [32:0] w_r0_ext;
    logic [32:0] w_r1_ext;
    logic [2:0]  w_cmp;
    logic        w_true_taken;
    logic        w_cond_jmp;
    logic        w_dir_mismatch;
    logic        w_type_mismatch;

    // Prepending ~sign for signed compares maps two's complement onto an
    // order-preserving unsigned range, so one unsigned comparator serves both.
    assign w_r0_ext = {~i_r0[31] & i_cmp_type[c_CMP_SIGNED], i_r0};
    assign w_r1_ext = {~i_r1[31] & i_cmp_type[c_CMP_SIGNED], i_r1};

    // Bit order matches cmp_type[3:1]: {lt, eq, gt}
    assign w_cmp = {w_r1_ext < w_r0_ext, w_r1_ext == w_r0_ext, w_r1_ext > w_r0_ext};

    assign w_true_taken = |(w_cmp & i_cmp_type[c_CMP_LT:c_CMP_GT]);
    assign w_cond_jmp   = (|i_cmp_type[c_CMP_LT:c_CMP_GT]) & ~(&i_cmp_type[c_CMP_LT:c_CMP_GT]);

    // A taken prediction only counts if it was made for this slot of the pair
    assign w_dir_mismatch  = (i_predict.taken & (i_predict.pc_off == i_pc[2])) != w_true_taken;
    assign w_type_mismatch = i_target_type != i_predict.target_type;

    assign o_miss = i_valid & (w_true_taken | i_predict.taken)
                  & ((i_predict.predict_pc != i_target) | w_dir_mismatch);

    assign o_need_update = (i_valid & ((i_target_type != _BPU_TARGET_NPC) | w_type_mismatch))
                         | o_miss;

    assign o_redirect_pc = w_true_taken ? i_target : i_pc + 32'd4;

    always_comb begin
        o_corr                      = '0;
        o_corr.pc                   = i_pc;
        o_corr.miss                 = o_miss;
        o_corr.true_taken           = w_true_taken;
        o_corr.true_conditional_jmp = w_cond_jmp;
        o_corr.true_target_type     = i_target_type;
        o_corr.true_target          = i_target;
        o_corr.ras_ptr              = i_predict.ras_ptr;
        o_corr.ras_miss_type        = '0;
        // An unpredicted call/return means the RAS pointer was not moved
        // speculatively; apply the push/pop here and let it wrap.
        if (w_type_mismatch) begin
            if (i_target_type == _BPU_TARGET_CALL) begin
                o_corr.ras_ptr       = i_predict.ras_ptr + c_RAS_ONE;
                o_corr.ras_miss_type = '1;
            end else if (i_target_type == _BPU_TARGET_RETURN) begin
                o_corr.ras_ptr       = i_predict.ras_ptr - c_RAS_ONE;
                o_corr.ras_miss_type = '1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_jmp_multi.sv
`default_nettype none
// ============================================================================
//  Module      : core_jmp_multi
//  Description : Multi-lane branch resolution unit. Resolves NUM_LANES
//                branches per cycle, issues a registered redirect for the
//                oldest mispredicting lane, queues BPU corrections in a
//                DEPTH-entry FIFO and keeps saturating performance counters.
//  Ports       : clk, rst_n (sync, active low), flush_i
//                valid_i/target_type_i/cmp_type_i/bpu_predict_i/pc_i/
//                target_i/r0_i/r1_i  per-lane branch inputs (lane 0 oldest)
//                ready_o             correction FIFO has a free slot
//                jmp_o/jmp_lane_o/target_o  registered redirect
//                corr_valid_o/corr_ready_i/corr_o  correction FIFO head
//                cnt_branch_o/cnt_miss_o/cnt_drop_o  saturating counters
//  Revision    : 1.0  initial release
// ============================================================================
module core_jmp_multi
    import core_jmp_multi_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush_i,
    input  logic [NUM_LANES-1:0]                       valid_i,
    input  logic [NUM_LANES-1:0][1:0]                  target_type_i,
    input  logic [NUM_LANES-1:0][3:0]                  cmp_type_i,
    input  bpu_predict_t [NUM_LANES-1:0]               bpu_predict_i,
    input  logic [NUM_LANES-1:0][31:0]                 pc_i,
    input  logic [NUM_LANES-1:0][31:0]                 target_i,
    input  logic [NUM_LANES-1:0][31:0]                 r0_i,
    input  logic [NUM_LANES-1:0][31:0]                 r1_i,
    output logic                                       ready_o,
    output logic                                       jmp_o,
    output logic [$clog2(NUM_LANES > 1 ? NUM_LANES : 2)-1:0] jmp_lane_o,
    output logic [31:0]                                target_o,
    output logic                                       corr_valid_o,
    input  logic                                       corr_ready_i,
    output bpu_correct_t                               corr_o,
    output logic [CNT_W-1:0]                           cnt_branch_o,
    output logic [CNT_W-1:0]                           cnt_miss_o,
    output logic [CNT_W-1:0]                           cnt_drop_o
);

    localparam int LANE_W = $clog2(NUM_LANES > 1 ? NUM_LANES : 2);
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [PTR_W:0]   c_OCC_ONE = 1;
    localparam logic [PTR_W:0]   c_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

    // ------------------------------------------------------------------
    // Per-lane resolution
    // ------------------------------------------------------------------
    logic         [NUM_LANES-1:0]       w_miss;
    logic         [NUM_LANES-1:0]       w_need_update;
    logic         [NUM_LANES-1:0][31:0] w_redirect_pc;
    bpu_correct_t [NUM_LANES-1:0]       w_corr;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        core_jmp_lane u_lane (
            .i_valid       (valid_i[gi]),
            .i_target_type (target_type_i[gi]),
            .i_cmp_type    (cmp_type_i[gi]),
            .i_predict     (bpu_predict_i[gi]),
            .i_pc          (pc_i[gi]),
            .i_target      (target_i[gi]),
            .i_r0          (r0_i[gi]),
            .i_r1          (r1_i[gi]),
            .o_miss        (w_miss[gi]),
            .o_need_update (w_need_update[gi]),
            .o_redirect_pc (w_redirect_pc[gi]),
            .o_corr        (w_corr[gi])
        );
    end

    // ------------------------------------------------------------------
    // Survival, oldest-miss select, push select and counter increments
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] w_survive;
    logic                 w_miss_found;
    logic [LANE_W-1:0]    w_sel_lane;
    logic [31:0]          w_sel_pc;
    logic                 w_push_req;
    bpu_correct_t         w_push_data;
    logic [CNT_W-1:0]     w_extra_drop;
    logic [CNT_W-1:0]     w_branch_inc;

    always_comb begin
        logic w_lower_miss;
        w_lower_miss = 1'b0;
        w_survive    = '0;
        w_miss_found = 1'b0;
        w_sel_lane   = '0;
        w_sel_pc     = '0;
        w_push_req   = 1'b0;
        w_push_data  = '0;
        w_extra_drop = '0;
        w_branch_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            // Anything younger than a mispredicting lane is on the wrong path
            w_survive[i] = valid_i[i] & ~w_lower_miss & ~flush_i;
            w_lower_miss = w_lower_miss | w_miss[i];
            if (w_survive[i]) begin
                if (target_type_i[i] != _BPU_TARGET_NPC) begin
                    w_branch_inc = w_branch_inc + c_CNT_ONE;
                end
                if (w_miss[i]) begin
                    w_miss_found = 1'b1;
                    w_sel_lane   = LANE_W'(i);
                    w_sel_pc     = w_redirect_pc[i];
                end
                if (w_need_update[i]) begin
                    if (!w_push_req) begin
                        w_push_req  = 1'b1;
                        w_push_data = w_corr[i];
                    end else begin
                        w_extra_drop = w_extra_drop + c_CNT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect register
    // ------------------------------------------------------------------
    logic              r_jmp;
    logic [LANE_W-1:0] r_jmp_lane;
    logic [31:0]       r_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_jmp      <= 1'b0;
            r_jmp_lane <= '0;
            r_target   <= '0;
        end else begin
            r_jmp <= w_miss_found;
            if (w_miss_found) begin
                r_jmp_lane <= w_sel_lane;
                r_target   <= w_sel_pc;
            end
        end
    end

    assign jmp_o      = r_jmp;
    assign jmp_lane_o = r_jmp_lane;
    assign target_o   = r_target;

    // ------------------------------------------------------------------
    // Correction FIFO
    // ------------------------------------------------------------------
    bpu_correct_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_push_drop;

    assign w_full      = r_count == c_FULL;
    assign w_pop       = corr_valid_o & corr_ready_i;
    // When full, a same-cycle pop frees the slot the write lands in
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_push_drop = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_OCC_ONE;
                2'b01:   r_count <= r_count - c_OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign corr_valid_o = r_count != '0;
    assign ready_o      = r_count < c_FULL;
    assign corr_o       = corr_valid_o ? r_mem[r_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_miss;
    logic [CNT_W-1:0] r_cnt_drop;
    logic [CNT_W-1:0] w_drop_inc;
    logic [CNT_W:0]   w_branch_sum;
    logic [CNT_W:0]   w_miss_sum;
    logic [CNT_W:0]   w_drop_sum;

    assign w_drop_inc   = w_extra_drop + {{(CNT_W-1){1'b0}}, w_push_drop};
    assign w_branch_sum = {1'b0, r_cnt_branch} + {1'b0, w_branch_inc};
    assign w_miss_sum   = {1'b0, r_cnt_miss} + {{CNT_W{1'b0}}, w_miss_found};
    assign w_drop_sum   = {1'b0, r_cnt_drop} + {1'b0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_branch <= '0;
            r_cnt_miss   <= '0;
            r_cnt_drop   <= '0;
        end else begin
            r_cnt_branch <= w_branch_sum[CNT_W] ? '1 : w_branch_sum[CNT_W-1:0];
            r_cnt_miss   <= w_miss_sum[CNT_W]   ? '1 : w_miss_sum[CNT_W-1:0];
            r_cnt_drop   <= w_drop_sum[CNT_W]   ? '1 : w_drop_sum[CNT_W-1:0];
        end
    end

    assign cnt_branch_o = r_cnt_branch;
    assign cnt_miss_o   = r_cnt_miss;
    assign cnt_drop_o   = r_cnt_drop;

endmodule
`default_nettype wire

// File: tb/tb_core_jmp_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_jmp_multi
//  Description : Self-checking bench for core_jmp_multi. A driver applies
//                directed and random branch traffic and pushes expected
//                results into queues; a monitor compares them against the
//                DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_jmp_multi;
    import core_jmp_multi_pkg::*;

    localparam int NL    = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    logic corr_ready_i;
    logic [NL-1:0]             valid_i;
    logic [NL-1:0][1:0]        target_type_i;
    logic [NL-1:0][3:0]        cmp_type_i;
    bpu_predict_t [NL-1:0]     bpu_predict_i;
    logic [NL-1:0][31:0]       pc_i;
    logic [NL-1:0][31:0]       target_i;
    logic [NL-1:0][31:0]       r0_i;
    logic [NL-1:0][31:0]       r1_i;
    logic                      ready_o;
    logic                      jmp_o;
    logic [0:0]                jmp_lane_o;
    logic [31:0]               target_o;
    logic                      corr_valid_o;
    bpu_correct_t              corr_o;
    logic [CNT_W-1:0]          cnt_branch_o;
    logic [CNT_W-1:0]          cnt_miss_o;
    logic [CNT_W-1:0]          cnt_drop_o;

    core_jmp_multi #(.NUM_LANES(NL), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .target_type_i (target_type_i),
        .cmp_type_i    (cmp_type_i),
        .bpu_predict_i (bpu_predict_i),
        .pc_i          (pc_i),
        .target_i      (target_i),
        .r0_i          (r0_i),
        .r1_i          (r1_i),
        .ready_o       (ready_o),
        .jmp_o         (jmp_o),
        .jmp_lane_o    (jmp_lane_o),
        .target_o      (target_o),
        .corr_valid_o  (corr_valid_o),
        .corr_ready_i  (corr_ready_i),
        .corr_o        (corr_o),
        .cnt_branch_o  (cnt_branch_o),
        .cnt_miss_o    (cnt_miss_o),
        .cnt_drop_o    (cnt_drop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned      stamp;
        logic             jmp;
        logic             lane;
        logic [31:0]      target;
        logic             ready;
        logic             cvalid;
        logic [CNT_W-1:0] br;
        logic [CNT_W-1:0] ms;
        logic [CNT_W-1:0] dr;
    } exp_t;

    exp_t         exp_q[$];
    bpu_correct_t corr_q[$];
    int           errors = 0;
    int           checks = 0;
    int unsigned  cyc    = 0;

    // Reference model state
    int               m_count;
    logic             m_lane;
    logic [31:0]      m_target;
    logic [CNT_W-1:0] m_br, m_ms, m_dr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic model_taken(logic [3:0] ct, logic [31:0] r0, logic [31:0] r1);
        logic lt, gt, eq;
        if (ct[0]) begin
            lt = $signed(r1) < $signed(r0);
            gt = $signed(r1) > $signed(r0);
        end else begin
            lt = r1 < r0;
            gt = r1 > r0;
        end
        eq = (r1 == r0);
        return (ct[3] && lt) || (ct[2] && eq) || (ct[1] && gt);
    endfunction

    function automatic logic [CNT_W-1:0] sat(logic [CNT_W-1:0] a, int inc);
        longint s;
        longint lim;
        lim = (longint'(1) << CNT_W) - 1;
        s   = longint'(a) + longint'(inc);
        return (s > lim) ? '1 : CNT_W'(s);
    endfunction

    function automatic bpu_correct_t model_corr(int i, logic tk, logic ms);
        bpu_correct_t c;
        bpu_predict_t p;
        int           tt;
        p  = bpu_predict_i[i];
        tt = int'(target_type_i[i]);
        c.pc                   = pc_i[i];
        c.miss                 = ms;
        c.true_taken           = tk;
        c.true_conditional_jmp = (cmp_type_i[i][3:1] != 3'b000) && (cmp_type_i[i][3:1] != 3'b111);
        c.true_target_type     = target_type_i[i];
        c.true_target          = target_i[i];
        c.ras_ptr              = p.ras_ptr;
        c.ras_miss_type        = 2'b00;
        if (tt == 1 && p.target_type != 2'd1) begin
            c.ras_ptr       = 3'((int'(p.ras_ptr) + 1) % 8);
            c.ras_miss_type = 2'b11;
        end else if (tt == 2 && p.target_type != 2'd2) begin
            c.ras_ptr       = 3'((int'(p.ras_ptr) + 7) % 8);
            c.ras_miss_type = 2'b11;
        end
        return c;
    endfunction

    // Compute the expected outcome of the current inputs, then clock them in
    task automatic step();
        exp_t         e;
        bpu_correct_t c;
        logic         killed, found, pushed, pop, tk, ms, nu;
        int           drops, brinc;
        bpu_predict_t p;
        found = 1'b0;
        if (!rst_n) begin
            m_count  = 0;
            corr_q.delete();
            m_lane   = 1'b0;
            m_target = '0;
            m_br = '0; m_ms = '0; m_dr = '0;
        end else begin
            killed = flush_i;
            pushed = 1'b0;
            drops  = 0;
            brinc  = 0;
            c      = '0;
            for (int i = 0; i < NL; i++) begin
                if (valid_i[i] && !killed) begin
                    p  = bpu_predict_i[i];
                    tk = model_taken(cmp_type_i[i], r0_i[i], r1_i[i]);
                    ms = (tk || p.taken) &&
                         ((p.predict_pc != target_i[i]) || ((p.taken && (p.pc_off == pc_i[i][2])) != tk));
                    nu = (target_type_i[i] != 2'd0) || (target_type_i[i] != p.target_type) || ms;
                    if (target_type_i[i] != 2'd0) brinc++;
                    if (nu) begin
                        if (!pushed) begin
                            pushed = 1'b1;
                            c      = model_corr(i, tk, ms);
                        end else begin
                            drops++;
                        end
                    end
                    if (ms) begin
                        found    = 1'b1;
                        m_lane   = 1'(i);
                        m_target = tk ? target_i[i] : pc_i[i] + 32'd4;
                        killed   = 1'b1;
                    end
                end
            end
            pop = (m_count > 0) && corr_ready_i;
            if (pushed) begin
                if (m_count < DEPTH || pop) begin
                    corr_q.push_back(c);
                    m_count++;
                end else begin
                    drops++;
                end
            end
            if (pop) m_count--;
            m_br = sat(m_br, brinc);
            m_ms = sat(m_ms, found ? 1 : 0);
            m_dr = sat(m_dr, drops);
        end
        e.stamp  = cyc + 1;
        e.jmp    = found;
        e.lane   = m_lane;
        e.target = m_target;
        e.ready  = (m_count < DEPTH);
        e.cvalid = (m_count > 0);
        e.br     = m_br;
        e.ms     = m_ms;
        e.dr     = m_dr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare FIFO pops and per-cycle registered outputs
    exp_t         mon_e;
    bpu_correct_t mon_c;
    always @(negedge clk) begin
        if (rst_n && corr_valid_o && corr_ready_i) begin
            if (corr_q.size() == 0) begin
                chk("corr_unexpected_pop", 128'd1, 128'd0);
            end else begin
                mon_c = corr_q.pop_front();
                chk("corr_o", 128'(corr_o), 128'(mon_c));
            end
        end
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("jmp_o", 128'(jmp_o), 128'(mon_e.jmp));
            chk("jmp_lane_o", 128'(jmp_lane_o), 128'(mon_e.lane));
            chk("target_o", 128'(target_o), 128'(mon_e.target));
            chk("ready_o", 128'(ready_o), 128'(mon_e.ready));
            chk("corr_valid_o", 128'(corr_valid_o), 128'(mon_e.cvalid));
            chk("cnt_branch_o", 128'(cnt_branch_o), 128'(mon_e.br));
            chk("cnt_miss_o", 128'(cnt_miss_o), 128'(mon_e.ms));
            chk("cnt_drop_o", 128'(cnt_drop_o), 128'(mon_e.dr));
        end
    end

    task automatic set_idle();
        flush_i       = 1'b0;
        valid_i       = '0;
        target_type_i = '0;
        cmp_type_i    = '0;
        bpu_predict_i = '0;
        pc_i          = '0;
        target_i      = '0;
        r0_i          = '0;
        r1_i          = '0;
    endtask

    task automatic set_lane(int i, logic [1:0] tt, logic [3:0] ct, logic [31:0] pc,
                            logic [31:0] tgt, logic [31:0] r0, logic [31:0] r1,
                            logic ptk, logic [1:0] ptt, logic [31:0] ppc, logic poff,
                            logic [2:0] ras);
        valid_i[i]                   = 1'b1;
        target_type_i[i]             = tt;
        cmp_type_i[i]                = ct;
        pc_i[i]                      = pc;
        target_i[i]                  = tgt;
        r0_i[i]                      = r0;
        r1_i[i]                      = r1;
        bpu_predict_i[i].taken       = ptk;
        bpu_predict_i[i].target_type = ptt;
        bpu_predict_i[i].predict_pc  = ppc;
        bpu_predict_i[i].pc_off      = poff;
        bpu_predict_i[i].ras_ptr     = ras;
    endtask

    task automatic idle(int n);
        set_idle();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        m_count = 0; m_lane = 1'b0; m_target = '0;
        m_br = '0; m_ms = '0; m_dr = '0;
        set_idle();
        rst_n        = 1'b0;
        corr_ready_i = 1'b0;
        step();
        step();
        rst_n        = 1'b1;
        corr_ready_i = 1'b1;
        idle(1);

        // Equality compare taken, predicted not-taken -> redirect to target
        set_idle();
        set_lane(0, 2'd3, 4'b0100, 32'h1C00_0000, 32'h1C00_0100, 32'd5, 32'd5,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
        step();
        idle(2);

        // Both lanes miss: oldest wins, younger lane killed
        set_idle();
        set_lane(0, 2'd3, 4'b0100, 32'h0000_1000, 32'h0000_2000, 32'd1, 32'd1,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
        set_lane(1, 2'd3, 4'b0100, 32'h0000_1004, 32'h0000_3000, 32'd2, 32'd2,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
        step();
        idle(2);

        // Signed vs unsigned compare of -1 against 1
        set_idle();
        set_lane(0, 2'd3, 4'b0011, 32'h0000_4000, 32'h0000_5000, 32'hFFFF_FFFF, 32'd1,
                 1'b1, 2'd3, 32'h0000_5000, 1'b0, 3'd0);
        step();
        set_idle();
        set_lane(0, 2'd3, 4'b0010, 32'h0000_4000, 32'h0000_5000, 32'hFFFF_FFFF, 32'd1,
                 1'b1, 2'd3, 32'h0000_5000, 1'b0, 3'd0);
        step();
        idle(2);

        // RAS pointer wrap on unpredicted CALL and RETURN
        set_idle();
        set_lane(0, 2'd1, 4'b0000, 32'h0000_6000, 32'h0000_7000, 32'd0, 32'd0,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd7);
        step();
        set_idle();
        set_lane(0, 2'd2, 4'b0000, 32'h0000_6100, 32'h0000_7100, 32'd0, 32'd0,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
        step();
        idle(3);

        // Fill the FIFO with the consumer stalled, overflow by one, then drain
        corr_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_idle();
            set_lane(0, 2'd1, 4'b0000, 32'h0000_8000 + 32'(k * 16), 32'h0000_9000, 32'd0, 32'd0,
                     1'b0, 2'd1, 32'h0, 1'b0, 3'(k));
            step();
        end
        corr_ready_i = 1'b1;
        idle(6);

        // Flush kills a mispredicting lane
        set_idle();
        set_lane(0, 2'd3, 4'b0100, 32'h0000_A000, 32'h0000_B000, 32'd3, 32'd3,
                 1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
        flush_i = 1'b1;
        step();
        idle(2);

        // Reset with three entries queued
        corr_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            set_lane(0, 2'd3, 4'b0000, 32'h0000_C000 + 32'(k * 8), 32'h0000_D000, 32'd0, 32'd0,
                     1'b0, 2'd3, 32'h0, 1'b0, 3'd0);
            step();
        end
        set_idle();
        rst_n = 1'b0;
        step();
        rst_n        = 1'b1;
        corr_ready_i = 1'b1;
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_idle();
            flush_i      = ($urandom_range(0, 15) == 0);
            corr_ready_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NL; i++) begin
                logic [31:0] pc, tgt, r0, r1, ppc;
                if ($urandom_range(0, 3) != 0) begin
                    pc  = $urandom & 32'hFFFF_FFFC;
                    tgt = $urandom & 32'hFFFF_FFFC;
                    r0  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
                    r1  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom_range(0, 3));
                    ppc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt;
                    set_lane(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pc, tgt, r0, r1,
                             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ppc,
                             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
                end
            end
            step();
        end

        // Drain with a bounded wait
        corr_ready_i = 1'b1;
        set_idle();
        for (int k = 0; k < 20 && (m_count > 0); k++) step();
        idle(2);
        @(negedge clk);
        #1;
        chk("corr_drain_remaining", 128'(corr_q.size()), 128'd0);
        chk("expect_drain_remaining", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
